// File: rtl/icache_line_server.sv
// Instruction-cache refill responder: fetches eight words for a missed line and returns it as one 256-bit line.
// Optional last-line buffer enabled by defining ICACHE_LINE_BUF_EN.
module icache_line_server #(
  parameter int unsigned LINE_WORDS      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         addr_send,
  input  logic [31:0]  addr,
  output logic         addr_ok,
  output logic         data_ok,
  output logic [255:0] memory_data,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata
);

  localparam logic [3:0] LW   = 4'(LINE_WORDS);
  localparam logic [3:0] MAXO = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ACCEPT, FETCH, DELIVER} state_t;

  state_t      state;
  logic [26:0] base_tag;
  logic [3:0]  issue_cnt;
  logic [3:0]  ret_cnt;
  logic        grant;
  logic        resp;
  logic [3:0]  issue_nxt;
  logic [3:0]  ret_nxt;
  logic [3:0]  outst_nxt;
  logic        unused_addr_bits;

`ifdef ICACHE_LINE_BUF_EN
  logic [26:0] buf_tag;
  logic        buf_valid;
`endif

  assign unused_addr_bits = ^addr[4:0];

  assign grant = mem_req & mem_gnt;
  // Late or surplus responses are dropped rather than allowed to corrupt the line.
  assign resp  = (state == FETCH) && mem_rvalid && (ret_cnt < LW);

  always_comb begin
    issue_nxt = issue_cnt + {3'b000, grant};
    ret_nxt   = ret_cnt + {3'b000, resp};
    outst_nxt = issue_nxt - ret_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base_tag    <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      addr_ok     <= 1'b0;
      data_ok     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      memory_data <= '0;
`ifdef ICACHE_LINE_BUF_EN
      buf_tag     <= '0;
      buf_valid   <= 1'b0;
`endif
    end else begin
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_send) begin
            base_tag <= addr[31:5];
            addr_ok  <= 1'b1;
            state    <= ACCEPT;
          end
        end
        ACCEPT: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
`ifdef ICACHE_LINE_BUF_EN
          if (buf_valid && (buf_tag == base_tag)) begin
            data_ok <= 1'b1;
            state   <= DELIVER;
          end else
`endif
          begin
            mem_req  <= 1'b1;
            mem_addr <= {base_tag, 5'b00000};
            state    <= FETCH;
          end
        end
        FETCH: begin
          issue_cnt <= issue_nxt;
          ret_cnt   <= ret_nxt;
          for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (resp && (ret_cnt == 4'(i)))
              memory_data[(LINE_WORDS-1-i)*32 +: 32] <= mem_rdata;
          end
          if (ret_nxt == LW) begin
            data_ok <= 1'b1;
            state   <= DELIVER;
`ifdef ICACHE_LINE_BUF_EN
            buf_tag   <= base_tag;
            buf_valid <= 1'b1;
`endif
          end else begin
            // Request line is registered, so it is computed from post-edge counts.
            mem_req  <= (issue_nxt < LW) && (outst_nxt < MAXO);
            mem_addr <= {base_tag, issue_nxt[2:0], 2'b00};
          end
        end
        DELIVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
